// File: rtl/meter_credit_counter.sv
// Parking-meter time-credit counter: edge-triggered adds/presets, 1 s decrement, saturation, status/blink.
// Optional BCD image of count when METER_BCD_OUT_EN is defined; otherwise bcd/bcd_valid are tied low.
module meter_credit_counter #(
  parameter int unsigned WIDTH      = 14,
  parameter int unsigned MAX_COUNT  = 9999,
  parameter int unsigned TICK_DIV   = 100000000,
  parameter int unsigned ADD0       = 10,
  parameter int unsigned ADD1       = 180,
  parameter int unsigned ADD2       = 200,
  parameter int unsigned ADD3       = 550,
  parameter int unsigned PRESET_A   = 10,
  parameter int unsigned PRESET_B   = 205,
  parameter int unsigned LOW_THRESH = 200
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       add,
  input  logic             preset_a,
  input  logic             preset_b,
  output logic [WIDTH-1:0] count,
  output logic             expired,
  output logic             low,
  output logic             blink,
  output logic [15:0]      bcd,
  output logic             bcd_valid
);

  localparam int unsigned DIVW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 2;
  localparam int unsigned SUMW = WIDTH + 2;

  logic [5:0]      in_now;
  logic [5:0]      in_s;
  logic [5:0]      in_p;
  logic [5:0]      held;
  logic [5:0]      edges;
  logic [DIVW-1:0] div;
  logic            tick;
  logic            half;
  logic            phase_off;
  logic            odd_sec;
  logic            dec;
  logic [SUMW-1:0] addsum;
  logic [SUMW-1:0] nxt;
  logic [WIDTH-1:0] sat;

  assign in_now = {preset_b, preset_a, add};
  // Levels already high while reset is asserted stay masked until they are seen low.
  assign edges  = in_s & ~in_p & ~held;

  assign tick = (div == DIVW'(TICK_DIV - 1));
  assign half = (div == DIVW'(TICK_DIV / 2 - 1));
  assign dec  = tick && (count != '0);

  always_comb begin
    addsum = '0;
    if (edges[0]) addsum = addsum + SUMW'(ADD0);
    if (edges[1]) addsum = addsum + SUMW'(ADD1);
    if (edges[2]) addsum = addsum + SUMW'(ADD2);
    if (edges[3]) addsum = addsum + SUMW'(ADD3);
    nxt = SUMW'(count) + addsum - SUMW'(dec);
    sat = (nxt > SUMW'(MAX_COUNT)) ? WIDTH'(MAX_COUNT) : nxt[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      in_s      <= '0;
      in_p      <= '0;
      held      <= in_now;
      div       <= '0;
      phase_off <= 1'b0;
      odd_sec   <= 1'b0;
    end else begin
      in_s <= in_now;
      in_p <= in_s;
      held <= held & in_now;
      if (edges[5] || edges[4]) begin
        count     <= edges[5] ? WIDTH'(PRESET_B) : WIDTH'(PRESET_A);
        div       <= '0;
        phase_off <= 1'b0;
        odd_sec   <= 1'b0;
      end else begin
        count <= sat;
        div   <= tick ? '0 : div + 1'b1;
        if (tick || half) phase_off <= ~phase_off;
        if (tick)         odd_sec   <= ~odd_sec;
      end
    end
  end

  assign expired = (count == '0);
  assign low     = !expired && (count < WIDTH'(LOW_THRESH));

  always_comb begin
    blink = 1'b1;
    if (expired)  blink = ~phase_off;
    else if (low) blink = ~phase_off & ~odd_sec;
  end

`ifdef METER_BCD_OUT_EN
  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

  bcd_state_t      state;
  logic [WIDTH-1:0] bin_sh;
  logic [WIDTH-1:0] last;
  logic [15:0]     acc;
  logic [15:0]     bcd_q;
  logic            valid_q;
  logic            have;
  logic [CNTW-1:0] bitcnt;

  function automatic logic [15:0] adj3(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    for (int unsigned i = 0; i < 4; i++) begin
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bin_sh  <= '0;
      last    <= '0;
      acc     <= '0;
      bcd_q   <= '0;
      valid_q <= 1'b0;
      have    <= 1'b0;
      bitcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!have || (count != last)) begin
            last    <= count;
            bin_sh  <= count;
            acc     <= '0;
            bitcnt  <= '0;
            valid_q <= 1'b0;
            have    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          {acc, bin_sh} <= {adj3(acc), bin_sh} << 1;
          bitcnt        <= bitcnt + 1'b1;
          if (bitcnt == CNTW'(WIDTH - 1)) state <= DONE;
        end
        DONE: begin
          // A result for a count that has since moved is dropped; IDLE restarts.
          if (count == last) begin
            bcd_q   <= acc;
            valid_q <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = valid_q && (count == last);
`else
  assign bcd       = 16'h0000;
  assign bcd_valid = 1'b0;
`endif

endmodule
